// File: rtl/noc_packetizer.sv
// noc_packetizer: turns a packet command plus payload words into head/body/tail flits for the node's flit fifo
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   packet command handshake; cmd_dest and cmd_len are latched on acceptance
//   dat_valid/ready   payload word handshake; dat_payload is carried unmodified in body/tail flits
//   fifo_wr_en/data   write port into the downstream flit fifo; fifo_full blocks writes
//   busy              a packet is in progress
//   pkt_cnt           completed packets, wraps at 2^16
module noc_packetizer #(
   parameter int D_WIDTH = 16,
   parameter int NODE_ID = 0,
   parameter int DEST_W  = 4,
   parameter int LEN_W   = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [DEST_W-1:0]  cmd_dest,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic               dat_valid,
   output logic               dat_ready,
   input  logic [D_WIDTH-3:0] dat_payload,
   output logic               fifo_wr_en,
   output logic [D_WIDTH-1:0] fifo_wr_data,
   input  logic               fifo_full,
   output logic               busy,
   output logic [15:0]        pkt_cnt
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HEAD = 2'd1;
   localparam logic [1:0] BODY = 2'd2;
   // zero bits below the header fields, so the header sits right under the type field
   localparam int PAD = D_WIDTH - 2 - 2 * DEST_W - LEN_W;

   logic [1:0]         state;
   logic [DEST_W-1:0]  dest_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   rem;
   logic [D_WIDTH-1:0] head_flit;

   assign head_flit = D_WIDTH'({len_q == '0 ? 2'b11 : 2'b01, dest_q, DEST_W'(NODE_ID), len_q}) << PAD;

   always_comb begin
      cmd_ready    = state == IDLE;
      dat_ready    = state == BODY && !fifo_full;
      fifo_wr_en   = !fifo_full && (state == HEAD || (state == BODY && dat_valid));
      fifo_wr_data = state == HEAD ? head_flit : {rem == LEN_W'(1) ? 2'b10 : 2'b00, dat_payload};
      busy         = state != IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         dest_q  <= '0;
         len_q   <= '0;
         rem     <= '0;
         pkt_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               dest_q <= cmd_dest;
               len_q  <= cmd_len;
               state  <= HEAD;
            end
            HEAD: if (fifo_wr_en) begin
               rem   <= len_q;
               state <= len_q == '0 ? IDLE : BODY;
               if (len_q == '0) pkt_cnt <= pkt_cnt + 16'd1;
            end
            BODY: if (fifo_wr_en) begin
               rem <= rem - LEN_W'(1);
               if (rem == LEN_W'(1)) begin
                  state   <= IDLE;
                  pkt_cnt <= pkt_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer: cycle-by-cycle vector table plus a back-to-back command sequence for noc_packetizer
module tb_noc_packetizer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_dest = '0;
   logic [5:0]  cmd_len = '0;
   logic        dat_valid = 1'b0;
   logic        dat_ready;
   logic [13:0] dat_payload = '0;
   logic        fifo_wr_en;
   logic [15:0] fifo_wr_data;
   logic        fifo_full = 1'b0;
   logic        busy;
   logic [15:0] pkt_cnt;
   int applied = 0;
   int errors = 0;

   always #5 clk = ~clk;

   noc_packetizer #(.D_WIDTH(16), .NODE_ID(3), .DEST_W(4), .LEN_W(6)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest), .cmd_len(cmd_len),
      .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_payload(dat_payload),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
      .busy(busy), .pkt_cnt(pkt_cnt)
   );

   typedef struct {
      logic        rst, cv;
      logic [3:0]  dest;
      logic [5:0]  len;
      logic        dv;
      logic [13:0] pay;
      logic        full, chk, cr, dr, we;
      logic [15:0] wd;
      logic        bz;
      logic [15:0] cnt;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(int r, int cv, int dest, int len, int dv, int pay, int full,
                               int chk, int cr, int dr, int we, int wd, int bz, int cnt);
      vec_t v;
      v.rst = 1'(r);  v.cv = 1'(cv); v.dest = 4'(dest); v.len = 6'(len);
      v.dv = 1'(dv);  v.pay = 14'(pay); v.full = 1'(full); v.chk = 1'(chk);
      v.cr = 1'(cr);  v.dr = 1'(dr); v.we = 1'(we); v.wd = 16'(wd);
      v.bz = 1'(bz);  v.cnt = 16'(cnt);
      return v;
   endfunction

   task automatic check(string nm, int cr, int dr, int we, int wd, int bz, int cnt);
      applied++;
      if (cmd_ready !== 1'(cr) || dat_ready !== 1'(dr) || fifo_wr_en !== 1'(we) ||
          (we != 0 && fifo_wr_data !== 16'(wd)) || busy !== 1'(bz) || pkt_cnt !== 16'(cnt)) begin
         errors++;
         $display("FAIL %s: got cr=%b dr=%b we=%b wd=%h busy=%b cnt=%0d, want cr=%0d dr=%0d we=%0d wd=%h busy=%0d cnt=%0d",
                  nm, cmd_ready, dat_ready, fifo_wr_en, fifo_wr_data, busy, pkt_cnt,
                  cr, dr, we, 16'(wd), bz, cnt);
      end
   endtask

   initial begin
      //                rst cv dst len dv pay      full chk cr dr we wd        bz cnt
      // single packet dest=5 len=2
      vt.push_back(mk(0, 1, 5,  2, 0, 'h0000, 0, 1, 1, 0, 0, 'h0000, 0, 0));
      vt.push_back(mk(0, 0, 0,  0, 0, 'h0000, 0, 1, 0, 0, 1, 'h54C2, 1, 0));
      vt.push_back(mk(0, 0, 0,  0, 1, 'h1234, 0, 1, 0, 1, 1, 'h1234, 1, 0));
      vt.push_back(mk(0, 0, 0,  0, 1, 'h0ABC, 0, 1, 0, 1, 1, 'h8ABC, 1, 0));
      // zero-length packet: head_tail only, payload offered but not consumed
      vt.push_back(mk(0, 1, 2,  0, 0, 'h0000, 0, 1, 1, 0, 0, 'h0000, 0, 1));
      vt.push_back(mk(0, 0, 0,  0, 1, 'h0777, 0, 1, 0, 0, 1, 'hC8C0, 1, 1));
      vt.push_back(mk(0, 0, 0,  0, 1, 'h0777, 0, 1, 1, 0, 0, 'h0000, 0, 2));
      // len=3 with 4-cycle stall in HEAD and 2-cycle stall in BODY
      vt.push_back(mk(0, 1, 1,  3, 0, 'h0000, 0, 1, 1, 0, 0, 'h0000, 0, 2));
      for (int i = 0; i < 4; i++)
         vt.push_back(mk(0, 0, 0, 0, 1, 'h0001, 1, 1, 0, 0, 0, 'h0000, 1, 2));
      vt.push_back(mk(0, 0, 0,  0, 0, 'h0000, 0, 1, 0, 0, 1, 'h44C3, 1, 2));
      vt.push_back(mk(0, 0, 0,  0, 1, 'h0011, 0, 1, 0, 1, 1, 'h0011, 1, 2));
      vt.push_back(mk(0, 0, 0,  0, 1, 'h0022, 1, 1, 0, 0, 0, 'h0000, 1, 2));
      vt.push_back(mk(0, 0, 0,  0, 1, 'h0022, 1, 1, 0, 0, 0, 'h0000, 1, 2));
      vt.push_back(mk(0, 0, 0,  0, 1, 'h0022, 0, 1, 0, 1, 1, 'h0022, 1, 2));
      vt.push_back(mk(0, 0, 0,  0, 1, 'h3FFF, 0, 1, 0, 1, 1, 'hBFFF, 1, 2));
      // len=3 with dat_valid 1,0,0,1,1 and cmd_valid held high
      vt.push_back(mk(0, 1, 15, 3, 0, 'h0000, 0, 1, 1, 0, 0, 'h0000, 0, 3));
      vt.push_back(mk(0, 1, 15, 3, 0, 'h0000, 0, 1, 0, 0, 1, 'h7CC3, 1, 3));
      vt.push_back(mk(0, 1, 15, 3, 1, 'h0101, 0, 1, 0, 1, 1, 'h0101, 1, 3));
      vt.push_back(mk(0, 1, 15, 3, 0, 'h0000, 0, 1, 0, 1, 0, 'h0000, 1, 3));
      vt.push_back(mk(0, 1, 15, 3, 0, 'h0000, 0, 1, 0, 1, 0, 'h0000, 1, 3));
      vt.push_back(mk(0, 1, 15, 3, 1, 'h0202, 0, 1, 0, 1, 1, 'h0202, 1, 3));
      vt.push_back(mk(0, 1, 15, 3, 1, 'h0303, 0, 1, 0, 1, 1, 'h8303, 1, 3));
      vt.push_back(mk(0, 0, 0,  0, 0, 'h0000, 0, 1, 1, 0, 0, 'h0000, 0, 4));
      // reset in BODY after 1 of 4 payloads, then a fresh len=1 packet
      vt.push_back(mk(0, 1, 3,  4, 0, 'h0000, 0, 1, 1, 0, 0, 'h0000, 0, 4));
      vt.push_back(mk(0, 0, 0,  0, 0, 'h0000, 0, 1, 0, 0, 1, 'h4CC4, 1, 4));
      vt.push_back(mk(0, 0, 0,  0, 1, 'h0AAA, 0, 1, 0, 1, 1, 'h0AAA, 1, 4));
      vt.push_back(mk(1, 0, 0,  0, 0, 'h0BBB, 0, 0, 0, 0, 0, 'h0000, 0, 0));
      vt.push_back(mk(0, 0, 0,  0, 1, 'h0CCC, 0, 1, 1, 0, 0, 'h0000, 0, 0));
      vt.push_back(mk(0, 1, 6,  1, 0, 'h0000, 0, 1, 1, 0, 0, 'h0000, 0, 0));
      vt.push_back(mk(0, 0, 0,  0, 0, 'h0000, 0, 1, 0, 0, 1, 'h58C1, 1, 0));
      vt.push_back(mk(0, 0, 0,  0, 1, 'h1555, 0, 1, 0, 1, 1, 'h9555, 1, 0));
      vt.push_back(mk(0, 0, 0,  0, 0, 'h0000, 0, 1, 1, 0, 0, 'h0000, 0, 1));

      @(posedge clk);
      @(posedge clk);
      foreach (vt[i]) begin
         @(posedge clk);
         #1;
         rst = vt[i].rst; cmd_valid = vt[i].cv; cmd_dest = vt[i].dest; cmd_len = vt[i].len;
         dat_valid = vt[i].dv; dat_payload = vt[i].pay; fifo_full = vt[i].full;
         @(negedge clk);
         if (vt[i].chk)
            check($sformatf("vec%0d", i), int'(vt[i].cr), int'(vt[i].dr), int'(vt[i].we),
                  int'(vt[i].wd), int'(vt[i].bz), int'(vt[i].cnt));
      end

      // back-to-back len=1 packets with cmd_valid held: accept, head, tail, repeat
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         #1;
         rst = 1'b0; cmd_valid = 1'b1; cmd_dest = 4'd9; cmd_len = 6'd1;
         dat_valid = 1'b1; dat_payload = 14'(100 + i); fifo_full = 1'b0;
         @(negedge clk);
         if (i % 3 == 0)      check($sformatf("b2b_idle%0d", i), 1, 0, 0, 0, 0, 1 + i / 3);
         else if (i % 3 == 1) check($sformatf("b2b_head%0d", i), 0, 0, 1, 'h64C1, 1, 1 + i / 3);
         else                 check($sformatf("b2b_tail%0d", i), 0, 1, 1, 'h8000 | (100 + i), 1, 1 + i / 3);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0; dat_valid = 1'b0;
      @(negedge clk);
      check("b2b_done", 1, 0, 0, 0, 0, 4);

      $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
      $finish;
   end
endmodule
